// File: rtl/ct_ifu_inv_seq_pkg.sv
// Shared IFU constants for the bulk-invalidate sequencer: state encoding,
// default array depths and job-mask bit positions.
package ct_ifu_inv_seq_pkg;

    typedef enum logic [1:0] {
        INV_IDLE = 2'b00,
        INV_RUN  = 2'b01,
        INV_DONE = 2'b10
    } inv_state_e;

    localparam int INV_ICACHE_DEPTH = 256;
    localparam int INV_BHT_DEPTH    = 1024;
    localparam int INV_BTB_DEPTH    = 1024;
    localparam int INV_IDX_W        = 10;

    // job mask bit positions
    localparam int INV_IC  = 0;
    localparam int INV_BHT = 1;
    localparam int INV_BTB = 2;

    typedef logic [2:0] inv_mask_t;

endpackage

// File: rtl/ct_ifu_inv_seq_if.sv
// Request/grant/invalidate bundle between cp0/vector/ifctrl and the
// invalidate sequencer. slave = sequencer side, master = its environment.
interface ct_ifu_inv_seq_if import ct_ifu_inv_seq_pkg::*; #(
    parameter int IDX_W = INV_IDX_W
) ();

    logic             ifu_cp0_rst_inv_req;
    logic             cp0_ifu_icache_inv_req;
    logic             cp0_ifu_bht_inv_req;
    logic             cp0_ifu_btb_inv_req;
    logic             ifctrl_inv_grant;
    logic             inv_icache_vld;
    logic             inv_bht_vld;
    logic             inv_btb_vld;
    logic [IDX_W-1:0] inv_index;
    logic             cp0_ifu_rst_inv_done;
    logic             ifu_cp0_icache_inv_done;
    logic             ifu_cp0_bht_inv_done;
    logic             ifu_cp0_btb_inv_done;
    logic             inv_seq_busy;

    modport slave (
        input  ifu_cp0_rst_inv_req, cp0_ifu_icache_inv_req, cp0_ifu_bht_inv_req,
               cp0_ifu_btb_inv_req, ifctrl_inv_grant,
        output inv_icache_vld, inv_bht_vld, inv_btb_vld, inv_index,
               cp0_ifu_rst_inv_done, ifu_cp0_icache_inv_done,
               ifu_cp0_bht_inv_done, ifu_cp0_btb_inv_done, inv_seq_busy
    );

    modport master (
        output ifu_cp0_rst_inv_req, cp0_ifu_icache_inv_req, cp0_ifu_bht_inv_req,
               cp0_ifu_btb_inv_req, ifctrl_inv_grant,
        input  inv_icache_vld, inv_bht_vld, inv_btb_vld, inv_index,
               cp0_ifu_rst_inv_done, ifu_cp0_icache_inv_done,
               ifu_cp0_bht_inv_done, ifu_cp0_btb_inv_done, inv_seq_busy
    );

endinterface

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate: enable is captured while the clock is low so the
// gated clock never glitches.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en;
    logic clk_en_lat;

    assign clk_en = (global_en & (module_en | local_en)) | external_en;

    always_latch begin
        if (!clk_in)
            clk_en_lat <= clk_en | pad_yy_icg_scan_en;
    end

    assign clk_out = clk_in & clk_en_lat;

endmodule

// File: rtl/ct_ifu_inv_seq.sv
// IFU bulk-invalidate sequencer: walks one index over the icache tag, BHT and
// BTB write ports for the post-reset job and for software invalidate-all jobs.
module ct_ifu_inv_seq import ct_ifu_inv_seq_pkg::*; #(
    parameter int ICACHE_DEPTH = INV_ICACHE_DEPTH,
    parameter int BHT_DEPTH    = INV_BHT_DEPTH,
    parameter int BTB_DEPTH    = INV_BTB_DEPTH,
    parameter int IDX_W        = INV_IDX_W
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst_b,
    input  logic            cp0_yy_clk_en,
    input  logic            cp0_ifu_icg_en,
    input  logic            pad_yy_icg_scan_en,
    ct_ifu_inv_seq_if.slave inv_if
);

    localparam logic [IDX_W:0] IC_D  = (IDX_W+1)'(ICACHE_DEPTH);
    localparam logic [IDX_W:0] BHT_D = (IDX_W+1)'(BHT_DEPTH);
    localparam logic [IDX_W:0] BTB_D = (IDX_W+1)'(BTB_DEPTH);
    localparam logic [IDX_W:0] ONE_W = (IDX_W+1)'(1);

    inv_state_e       state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    inv_mask_t        job_mask, job_mask_nxt;
    logic             job_rst, job_rst_nxt;
    logic             rst_pend, ic_pend, bht_pend, btb_pend;
    logic             any_req, any_pend, sw_load, rst_load;
    logic             clk_en, inv_clk;
    logic             run, done, grant, last;
    logic [IDX_W:0]   idx_w, max_d;

    assign grant = inv_if.ifctrl_inv_grant;

    assign any_req  = inv_if.ifu_cp0_rst_inv_req | inv_if.cp0_ifu_icache_inv_req
                    | inv_if.cp0_ifu_bht_inv_req | inv_if.cp0_ifu_btb_inv_req;
    assign any_pend = rst_pend | ic_pend | bht_pend | btb_pend;
    assign clk_en   = any_req | any_pend | (state != INV_IDLE);

    gated_clk_cell x_inv_seq_clk (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_ifu_icg_en),
        .local_en           (clk_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (inv_clk)
    );

    // Reset job wins in IDLE; software bits stay pending behind it.
    assign rst_load = (state == INV_IDLE) & rst_pend;
    assign sw_load  = (state == INV_IDLE) & ~rst_pend & any_pend;

    always_ff @(posedge inv_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rst_pend <= 1'b0;
            ic_pend  <= 1'b0;
            bht_pend <= 1'b0;
            btb_pend <= 1'b0;
        end else begin
            rst_pend <= inv_if.ifu_cp0_rst_inv_req    | (rst_pend & ~rst_load);
            ic_pend  <= inv_if.cp0_ifu_icache_inv_req | (ic_pend  & ~sw_load);
            bht_pend <= inv_if.cp0_ifu_bht_inv_req    | (bht_pend & ~sw_load);
            btb_pend <= inv_if.cp0_ifu_btb_inv_req    | (btb_pend & ~sw_load);
        end
    end

    // Walk length is the deepest array in the job.
    always_comb begin
        max_d = '0;
        if (job_mask[INV_IC]  && (IC_D  > max_d)) max_d = IC_D;
        if (job_mask[INV_BHT] && (BHT_D > max_d)) max_d = BHT_D;
        if (job_mask[INV_BTB] && (BTB_D > max_d)) max_d = BTB_D;
    end

    assign idx_w = {1'b0, idx};
    assign last  = (idx_w == (max_d - ONE_W));

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        job_mask_nxt = job_mask;
        job_rst_nxt  = job_rst;
        case (state)
            INV_IDLE: begin
                if (any_pend) begin
                    job_rst_nxt  = rst_pend;
                    job_mask_nxt = rst_pend ? 3'b111 : {btb_pend, bht_pend, ic_pend};
                    idx_nxt      = '0;
                    state_nxt    = INV_RUN;
                end
            end
            INV_RUN: begin
                if (grant) begin
                    if (last) begin
                        idx_nxt   = '0;
                        state_nxt = INV_DONE;
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end
            end
            INV_DONE: state_nxt = INV_IDLE;
            default:  state_nxt = INV_IDLE;
        endcase
    end

    always_ff @(posedge inv_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= INV_IDLE;
            idx      <= '0;
            job_mask <= '0;
            job_rst  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            job_mask <= job_mask_nxt;
            job_rst  <= job_rst_nxt;
        end
    end

    assign run  = (state == INV_RUN);
    assign done = (state == INV_DONE);

    assign inv_if.inv_icache_vld = run & job_mask[INV_IC]  & (idx_w < IC_D)  & grant;
    assign inv_if.inv_bht_vld    = run & job_mask[INV_BHT] & (idx_w < BHT_D) & grant;
    assign inv_if.inv_btb_vld    = run & job_mask[INV_BTB] & (idx_w < BTB_D) & grant;
    assign inv_if.inv_index      = idx;

    assign inv_if.cp0_ifu_rst_inv_done    = done &  job_rst;
    assign inv_if.ifu_cp0_icache_inv_done = done & ~job_rst & job_mask[INV_IC];
    assign inv_if.ifu_cp0_bht_inv_done    = done & ~job_rst & job_mask[INV_BHT];
    assign inv_if.ifu_cp0_btb_inv_done    = done & ~job_rst & job_mask[INV_BTB];
    assign inv_if.inv_seq_busy            = (state != INV_IDLE);

endmodule

// File: doc/ct_ifu_inv_seq.md
# ct_ifu_inv_seq

Sequencer that performs bulk invalidation of the IFU arrays (icache tag, BHT, BTB) by walking an index counter over each array's write port. It serves the vector block's post-reset invalidate request (answering with `cp0_ifu_rst_inv_done`, which releases the vector RESET state) and software invalidate-all requests from cp0. It sits in the IFU between cp0/vector and ifctrl; ifctrl owns the array ports and grants them per cycle.

## Interface
Parameters:
- `ICACHE_DEPTH`, 256: icache tag sets.
- `BHT_DEPTH`, 1024: BHT entries.
- `BTB_DEPTH`, 1024: BTB entries.
- `IDX_W`, 10: index width; must satisfy 2^IDX_W >= max depth.

Ports:
- `forever_cpuclk`  in  1  clock.
- `cpurst_b`  in  1  asynchronous active-low reset.
- `cp0_yy_clk_en`, `cp0_ifu_icg_en`, `pad_yy_icg_scan_en`  in  1  clock-gate controls.
- `ifu_cp0_rst_inv_req`  in  1  one-cycle pulse from the vector FSM on entering RESET.
- `cp0_ifu_icache_inv_req`, `cp0_ifu_bht_inv_req`, `cp0_ifu_btb_inv_req`  in  1  software invalidate-all pulses.
- `ifctrl_inv_grant`  in  1  array write ports available this cycle.
- `inv_icache_vld`, `inv_bht_vld`, `inv_btb_vld`  out  1  invalidate the entry at `inv_index` in that array.
- `inv_index`  out  IDX_W  current entry index.
- `cp0_ifu_rst_inv_done`  out  1  one-cycle pulse; reset job complete.
- `ifu_cp0_icache_inv_done`, `ifu_cp0_bht_inv_done`, `ifu_cp0_btb_inv_done`  out  1  one-cycle pulses; software job complete per array.
- `inv_seq_busy`  out  1  state is not IDLE.

## Operation
- Pending register bits: `rst_pend`, `ic_pend`, `bht_pend`, `btb_pend`.
  - Each is set by its request pulse.
  - Each is cleared when its job is loaded in IDLE.
  - A set and a clear in the same cycle resolve to set.
- FSM states are IDLE, RUN and DONE. All reset to IDLE.
- IDLE:
  - If `rst_pend`: job_mask = all three arrays, job_rst = 1.
  - Otherwise, if any software pending bit is set: job_mask = the set pending bits, job_rst = 0.
  - Load the job, clear `idx`, go to RUN.
- RUN:
  - `inv_X_vld` = job_mask[X] and (`idx` < X_DEPTH) and `ifctrl_inv_grant`.
  - The vld outputs are combinational from state, idx, mask and grant.
  - `idx` increments only when grant is high.
  - last = `idx` == (max DEPTH over job_mask) − 1. Last with grant goes to DONE.
- DONE, one cycle:
  - If job_rst: pulse `cp0_ifu_rst_inv_done`.
  - Otherwise: pulse `ifu_cp0_X_inv_done` for each X in job_mask.
  - Then go to IDLE.
- A request arriving during RUN or DONE only sets its pending bit. It is served after return to IDLE, so re-requesting an array mid-job causes one full rerun. Running jobs are never aborted.
- A reset request has priority over software requests in IDLE. Software bits left pending are served by the next job.
- `cpurst_b` low mid-job: all state returns immediately to reset values and the job is discarded. The vector block re-requests after reset.

## Timing
- Reset values:
  - state = IDLE; `idx` = 0.
  - job_mask = 0; job_rst = 0; all pending bits = 0.
  - All vld and done outputs = 0; `inv_index` = 0; `inv_seq_busy` = 0.
- Request pulse at cycle N:
  - Pending bit set at N+1; RUN entered at N+2.
  - With grant continuously high: first vld at N+2, index 0.
  - DONE and the done pulse at N+2+D, where D is the max masked depth.
  - IDLE at N+3+D.
- Defaults: reset job done at N+1026; icache-only job done at N+258.
- Grant low in cycle k: no vld, `idx` holds, and completion slips one cycle per low cycle.
- Back-to-back jobs: one IDLE cycle between a DONE and the next RUN.
- Clock gating: the gated clock is enabled by any request pulse, any pending bit, or state != IDLE.

## Structure
- Shared IFU package holds the state encoding and the default depth constants.
- Local clock gating uses one `gated_clk_cell` instance, named `x_inv_seq_clk`.
- No other sub-module; the pending bits, FSM and counter are flat.
- Target size is about 180 RTL lines.

## Test plan
- Reset release, rst pulse at cycle 3, grant held high:
  - `inv_btb_vld` is seen at indices 0..1023.
  - `inv_icache_vld` is seen only at indices 0..255.
  - `cp0_ifu_rst_inv_done` pulses exactly once, at cycle 1029.
- icache software pulse, grant toggling 1/0:
  - 256 vld cycles occur, with `idx` held on every low-grant cycle.
  - `ifu_cp0_icache_inv_done` pulses at cycle 2+512.
- BHT and BTB pulses in the same cycle:
  - A single job runs with both vld high for idx 0..1023.
  - Both done pulses fire in the same cycle.
- BTB pulse during a running icache job:
  - The icache job completes untouched.
  - One IDLE cycle follows, then a BTB job of 1024 entries.
- Reset pulse together with an icache software pulse:
  - The reset job runs first.
  - The icache job follows.
  - No software done fires during the reset job.
- `cpurst_b` asserted at idx 500:
  - All outputs return to 0 that cycle.
  - A new rst pulse restarts from index 0.
